// File: rtl/filter_arbiter.sv
// Round-robin arbiter granting one neighbor-filter FIFO per cycle into the shared
// force-evaluation pipeline, with a registered payload stage and grant counter.
module filter_arbiter #(
    parameter int NUM_FILTER = 4,
    parameter int DATA_WIDTH = 96,
    parameter int CNT_WIDTH  = 16,
    localparam int SEL_WIDTH = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FILTER-1:0]            filter_valid,
    input  logic [NUM_FILTER*DATA_WIDTH-1:0] filter_data,
    output logic [NUM_FILTER-1:0]            filter_rd_en,
    input  logic                             back_pressure,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_source,
    output logic [CNT_WIDTH-1:0]             pair_count
);

    localparam logic [SEL_WIDTH:0] NUM_SEL = (SEL_WIDTH+1)'(NUM_FILTER);

    logic [SEL_WIDTH-1:0]  rr_ptr;
    logic [NUM_FILTER-1:0] rot_p0;
    logic [SEL_WIDTH-1:0]  off_p0;
    logic [SEL_WIDTH-1:0]  win_p0;
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    // Reduce an index in [0, 2*NUM_FILTER) back into [0, NUM_FILTER).
    function automatic logic [SEL_WIDTH-1:0] wrap_sel(input logic [SEL_WIDTH:0] s);
        return (s >= NUM_SEL) ? SEL_WIDTH'(s - NUM_SEL) : SEL_WIDTH'(s);
    endfunction

    // Stage p0: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_p0 = NUM_FILTER'({filter_valid, filter_valid} >> rr_ptr);
        off_p0 = '0;
        for (int k = NUM_FILTER - 1; k >= 0; k--) begin
            if (rot_p0[k]) begin
                off_p0 = SEL_WIDTH'(k);
            end
        end
        win_p0 = wrap_sel({1'b0, rr_ptr} + {1'b0, off_p0});
        vld_p0 = (|filter_valid) && !back_pressure && !rst;
    end

    always_comb begin
        filter_rd_en = '0;
        data_p0      = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            if (win_p0 == SEL_WIDTH'(i)) begin
                filter_rd_en[i] = vld_p0;
                data_p0         = filter_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage p1: registered grant toward the force pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_source <= '0;
            pair_count <= '0;
        end else begin
            out_valid <= vld_p0;
            if (vld_p0) begin
                out_data   <= data_p0;
                out_source <= win_p0;
                rr_ptr     <= wrap_sel({1'b0, win_p0} + (SEL_WIDTH+1)'(1));
                pair_count <= pair_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_filter_arbiter.sv
// Bench for filter_arbiter: vector table, random traffic vs. a model, async-reset
// and counter-wrap sequences, all checked through an expected-output queue.
module tb_filter_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   filter_valid;
    logic [383:0] filter_data;
    logic         back_pressure;
    logic [3:0]   filter_rd_en;
    logic         out_valid;
    logic [95:0]  out_data;
    logic [1:0]   out_source;
    logic [15:0]  pair_count;

    logic [3:0]   rd_c4;
    logic         ov_c4;
    logic [95:0]  od_c4;
    logic [1:0]   os_c4;
    logic [3:0]   pc_c4;

    filter_arbiter dut (
        .clk(clk), .rst(rst), .filter_valid(filter_valid), .filter_data(filter_data),
        .filter_rd_en(filter_rd_en), .back_pressure(back_pressure), .out_valid(out_valid),
        .out_data(out_data), .out_source(out_source), .pair_count(pair_count)
    );

    filter_arbiter #(.CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst(rst), .filter_valid(filter_valid), .filter_data(filter_data),
        .filter_rd_en(rd_c4), .back_pressure(back_pressure), .out_valid(ov_c4),
        .out_data(od_c4), .out_source(os_c4), .pair_count(pc_c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       bp;
        logic [3:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [95:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t        q[$];
    vec_t        tbl[18];
    int          tests;
    int          fails;
    logic [1:0]  mptr;
    int          mcnt;
    logic [95:0] last_d;
    logic [1:0]  last_s;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] arb(input logic [3:0] v, input logic [1:0] p, input logic bp);
        int idx;
        if (bp) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            idx = (int'(p) + k) % 4;
            if (v[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    task automatic model_reset();
        q.delete();
        mptr   = 2'd0;
        mcnt   = 0;
        last_d = '0;
        last_s = '0;
    endtask

    task automatic step(input logic [3:0] v, input logic bp, input logic [3:0] exp_rd, input string nm);
        int   w;
        exp_t e;
        @(negedge clk);
        filter_valid  = v;
        back_pressure = bp;
        for (int i = 0; i < 12; i++) filter_data[i*32 +: 32] = $urandom;
        #1;
        chk({nm, ".rd_en"}, 128'(filter_rd_en), 128'(exp_rd));
        w = -1;
        for (int i = 0; i < 4; i++) if (exp_rd[i]) w = i;
        if (w >= 0) begin
            e.d = filter_data[w*96 +: 96];
            e.s = w[1:0];
            q.push_back(e);
            mptr = 2'((w + 1) % 4);
            mcnt++;
        end
        @(posedge clk);
        #1;
        chk({nm, ".out_valid"}, 128'(out_valid), 128'(w >= 0));
        if (w >= 0) begin
            if (q.size() == 0) begin
                chk({nm, ".queue"}, 128'(0), 128'(1));
            end else begin
                e      = q.pop_front();
                last_d = e.d;
                last_s = e.s;
            end
        end
        chk({nm, ".out_data"}, 128'(out_data), 128'(last_d));
        chk({nm, ".out_source"}, 128'(out_source), 128'(last_s));
        chk({nm, ".pair_count"}, 128'(pair_count), 128'(mcnt[15:0]));
        chk({nm, ".pair_count4"}, 128'(pc_c4), 128'(mcnt[3:0]));
        chk({nm, ".rr_ptr"}, 128'(dut.rr_ptr), 128'(mptr));
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] v;
        logic       bp;
        tests = 0;
        fails = 0;
        one   = 4'b0001;
        model_reset();

        // all four requesting from a fresh pointer
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
        // lone requester
        tbl[4]  = '{4'b0100, 1'b0, 4'b0100};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0100};
        tbl[6]  = '{4'b0100, 1'b0, 4'b0100};
        // pointer at 3, wrap to 0
        tbl[7]  = '{4'b1001, 1'b0, 4'b1000};
        tbl[8]  = '{4'b1001, 1'b0, 4'b0001};
        // back-pressure mid-stream
        tbl[9]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[10] = '{4'b1111, 1'b1, 4'b0000};
        tbl[11] = '{4'b1111, 1'b1, 4'b0000};
        tbl[12] = '{4'b1111, 1'b0, 4'b0100};
        tbl[13] = '{4'b1111, 1'b0, 4'b1000};
        // withdrawn requests, pointer skipping
        tbl[14] = '{4'b1010, 1'b0, 4'b0010};
        tbl[15] = '{4'b0000, 1'b0, 4'b0000};
        tbl[16] = '{4'b0011, 1'b0, 4'b0001};
        tbl[17] = '{4'b0000, 1'b0, 4'b0000};

        rst           = 1'b1;
        filter_valid  = 4'b1111;
        back_pressure = 1'b0;
        for (int i = 0; i < 12; i++) filter_data[i*32 +: 32] = $urandom;
        #2;
        chk("reset.rd_en", 128'(filter_rd_en), 128'(0));
        chk("reset.out_valid", 128'(out_valid), 128'(0));
        chk("reset.out_data", 128'(out_data), 128'(0));
        chk("reset.out_source", 128'(out_source), 128'(0));
        chk("reset.pair_count", 128'(pair_count), 128'(0));
        @(posedge clk);
        #1;
        chk("reset_clk.rd_en", 128'(filter_rd_en), 128'(0));
        chk("reset_clk.out_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        filter_valid = 4'b0000;
        rst          = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].valid, tbl[i].bp, tbl[i].exp_rd, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            v  = 4'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            step(v, bp, arb(v, mptr, bp), $sformatf("rnd%0d", i));
        end

        // asynchronous reset while grants are flowing
        step(4'b1111, 1'b0, one << mptr, "pre_rst");
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 128'(out_valid), 128'(0));
        chk("async_rst.pair_count", 128'(pair_count), 128'(0));
        chk("async_rst.pair_count4", 128'(pc_c4), 128'(0));
        chk("async_rst.rd_en", 128'(filter_rd_en), 128'(0));
        chk("async_rst.rr_ptr", 128'(dut.rr_ptr), 128'(0));
        model_reset();
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(4'b1111, 1'b0, one << mptr, $sformatf("wrap%0d", i));
        end
        chk("cnt4_after_17", 128'(pc_c4), 128'(4'd1));
        chk("cnt16_after_17", 128'(pair_count), 128'(16'd17));
        step(4'b0000, 1'b0, 4'b0000, "idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_arbiter.md
FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 SHALL have parameter NUM_FILTER, default 4, number of neighbor-filter requesters sharing one force-evaluation pipeline (legal 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 96, width of one particle-pair payload (3 x 32-bit fp displacement).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of granted-pair counter.
REQ-004 SHALL derive SEL_WIDTH = ceil(log2(NUM_FILTER)), minimum 1.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 filter_valid  input  NUM_FILTER  bit i high: filter i show-ahead FIFO non-empty, head payload valid.
REQ-008 filter_data  input  NUM_FILTER*DATA_WIDTH  filter i head payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 filter_rd_en  output  NUM_FILTER  one-hot/zero pop strobe to filter FIFOs, combinational.
REQ-010 back_pressure  input  1  high: force pipeline input buffer near-full, no new grants.
REQ-011 out_valid  output  1  registered, payload valid for force pipeline.
REQ-012 out_data  output  DATA_WIDTH  registered granted payload.
REQ-013 out_source  output  SEL_WIDTH  registered index of granted filter.
REQ-014 pair_count  output  CNT_WIDTH  registered total granted pairs since reset.

Function
REQ-015 SHALL keep a round-robin pointer rr_ptr (SEL_WIDTH bits) naming highest-priority filter.
REQ-016 Each cycle with back_pressure low, winner = first i with filter_valid[i] high, searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_FILTER.
REQ-017 filter_rd_en SHALL be one-hot at winner in the same cycle; all-zero if no valid request or back_pressure high.
REQ-018 At most one bit of filter_rd_en SHALL ever be high.
REQ-019 On grant edge: out_valid<=1, out_data<=winner payload, out_source<=winner; latency request-to-output exactly 1 cycle.
REQ-020 No-grant cycle: out_valid<=0 next edge; out_data, out_source hold previous values.
REQ-021 On grant: rr_ptr<=(winner+1) mod NUM_FILTER, wrapping NUM_FILTER-1 to 0; on no grant rr_ptr holds.
REQ-022 back_pressure high SHALL block grants that same cycle (combinational) and hold rr_ptr; pending requests stay un-popped.
REQ-023 Continuously requesting filter SHALL be granted at least once every NUM_FILTER grant cycles (starvation-free).
REQ-024 Sustained throughput SHALL be one grant per cycle while any request valid and back_pressure low.
REQ-025 pair_count SHALL increment by 1 per grant edge, wrapping 2^CNT_WIDTH-1 to 0.
REQ-026 Request deasserted in the same cycle it would win: not granted; next valid requester in order wins.

Reset
REQ-027 rst high SHALL immediately clear rr_ptr, out_valid, out_data, out_source, pair_count to 0, independent of clk.
REQ-028 filter_rd_en SHALL be all-zero while rst high, regardless of filter_valid.
REQ-029 Reset mid-operation SHALL drop any in-flight output (out_valid 0); first grant after release starts search at filter 0.

Verification
REQ-030 Reset then filter_valid=4'b1111 for 4 cycles, back_pressure=0 -> rd_en 0001,0010,0100,1000; out_source 0,1,2,3 one cycle later; pair_count=4.
REQ-031 Only filter 2 valid for 3 cycles -> rd_en=0100 each cycle, out_valid high 3 consecutive cycles, rr_ptr=3 after each grant.
REQ-032 filter_valid=1111, back_pressure high 2 cycles mid-stream -> rd_en=0000 those cycles, out_valid low next 2 cycles, rr_ptr unchanged, resumes at next filter in order.
REQ-033 rr_ptr=3, filter_valid=1001 -> winner 3 then 0 (wrap), out_source 3 then 0.
REQ-034 CNT_WIDTH=4, 17 consecutive grants -> pair_count reads 1 (wrap after 15).
REQ-035 rst asserted asynchronously between edges during active grants -> out_valid, pair_count, rd_en 0 immediately; after release with 1111 first grant to filter 0.
